// File: rtl/l2_fwd_stall_buf.sv
// l2_fwd_stall_buf
// Holds one forwarded coherence message that collided with an outstanding
// request-buffer entry. The forward is parked until that entry retires and is
// then replayed to the L2 controller over a valid/ready handshake. A
// saturating stall-age counter drives a sticky watchdog flag.
module l2_fwd_stall_buf #(
  parameter int N_REQS    = 4,
  parameter int REQS_BITS = $clog2(N_REQS),
  parameter int ADDR_BITS = 32,
  parameter int MSG_BITS  = 2,
  parameter int ID_BITS   = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_fwd_stall,
  input  logic                 clr_fwd_stall,
  input  logic                 set_fwd_stall_i,
  input  logic [REQS_BITS-1:0] fwd_stall_i_wr_data,
  input  logic [MSG_BITS-1:0]  fwd_msg_in,
  input  logic [ADDR_BITS-1:0] fwd_addr_in,
  input  logic [ID_BITS-1:0]   fwd_id_in,
  input  logic                 retire_valid,
  input  logic [REQS_BITS-1:0] retire_i,
  output logic                 fwd_stall,
  output logic [REQS_BITS-1:0] fwd_stall_i,
  output logic                 replay_valid,
  input  logic                 replay_ready,
  output logic [MSG_BITS-1:0]  replay_msg,
  output logic [ADDR_BITS-1:0] replay_addr,
  output logic [ID_BITS-1:0]   replay_id,
  output logic                 stall_timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STALLED = 2'd1;
  localparam logic [1:0] ST_REPLAY  = 2'd2;

  localparam int          AGE_BITS  = 10;
  localparam logic [9:0]  AGE_MAX   = 10'h3FF;
  localparam logic [9:0]  TIMEOUT_C = 10'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  logic [REQS_BITS-1:0] idx_q, idx_d;
  logic [MSG_BITS-1:0]  msg_q, msg_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [AGE_BITS-1:0]  age_q, age_d;
  logic                 timeout_q, timeout_d;
  logic                 fwd_stall_q, fwd_stall_d;
  logic                 replay_valid_q, replay_valid_d;

  logic capture;
  logic load;
  logic retire_hits_new;
  logic retire_hits_held;

  // A peek only parks the forward when it completed, flagged a stall, and
  // was not simultaneously cleared.
  assign capture          = set_fwd_stall_i & set_fwd_stall & ~clr_fwd_stall;
  assign retire_hits_new  = retire_valid && (retire_i == fwd_stall_i_wr_data);
  assign retire_hits_held = retire_valid && (retire_i == idx_q);

  // Next-state and payload-load decision.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          state_d = retire_hits_new ? ST_REPLAY : ST_STALLED;
        end
      end
      ST_STALLED: begin
        // Captures here are protocol errors and are dropped.
        if (retire_hits_held) state_d = ST_REPLAY;
      end
      ST_REPLAY: begin
        if (replay_ready) begin
          if (capture) begin
            load    = 1'b1;
            state_d = ST_STALLED;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload, stall age and registered output values.
  always_comb begin
    idx_d  = load ? fwd_stall_i_wr_data : idx_q;
    msg_d  = load ? fwd_msg_in          : msg_q;
    addr_d = load ? fwd_addr_in         : addr_q;
    id_d   = load ? fwd_id_in           : id_q;

    age_d = age_q;
    if (state_d == ST_STALLED && state_q != ST_STALLED) begin
      age_d = '0;
    end else if (state_q == ST_STALLED && age_q != AGE_MAX) begin
      age_d = age_q + 10'd1;
    end

    timeout_d      = timeout_q | ((state_q == ST_STALLED) && (age_q == TIMEOUT_C));
    fwd_stall_d    = (state_d != ST_IDLE);
    replay_valid_d = (state_d == ST_REPLAY);
  end

  // State registers; reset discards any held forward immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      msg_q          <= '0;
      addr_q         <= '0;
      id_q           <= '0;
      age_q          <= '0;
      timeout_q      <= 1'b0;
      fwd_stall_q    <= 1'b0;
      replay_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q        <= state_d;
      idx_q          <= idx_d;
      msg_q          <= msg_d;
      addr_q         <= addr_d;
      id_q           <= id_d;
      age_q          <= age_d;
      timeout_q      <= timeout_d;
      fwd_stall_q    <= fwd_stall_d;
      replay_valid_q <= replay_valid_d;
    end
  end

  assign fwd_stall     = fwd_stall_q;
  assign fwd_stall_i   = idx_q;
  assign replay_valid  = replay_valid_q;
  assign replay_msg    = msg_q;
  assign replay_addr   = addr_q;
  assign replay_id     = id_q;
  assign stall_timeout = timeout_q;

endmodule
